mem_arb2: RTL

Two-requester arbiter for the single-port 8-bit, 256-entry system memory. It sits between the memory and two bus masters: port 0 is normally the be8 core, port 1 a DMA/loader engine. It serialises their accesses with a req/rdy handshake, drives the memory address, write-enable and write-data lines, and returns read data. Selection between simultaneous requests is configurable, and lock-based bursts are capped in length.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arb2.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port system-memory arbiter.
// Holds the FSM state enum, port indices and the system memory geometry.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int P0     = 0;
    localparam int P1     = 1;
    localparam int MEM_AW = 8;
    localparam int MEM_DW = 8;
    localparam int HOLD_W = 4;

    function automatic logic [1:0] onehot(input int p);
        return (p == P1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for mem_arb2, one-hot result.
// MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       i_rr_last,
`endif
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[P0] && i_req[P1]) begin
`ifdef MEM_ARB_RR_EN
            // the port that was not served last wins the tie
            o_gnt = i_rr_last ? onehot(P0) : onehot(P1);
`else
            o_gnt = onehot(P0);
`endif
        end else if (i_req[P0]) begin
            o_gnt = onehot(P0);
        end else if (i_req[P1]) begin
            o_gnt = onehot(P1);
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester arbiter for the single-port system memory (IDLE/ACCESS/DONE FSM).
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          rdy0,
    output logic          rdy1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
`ifdef MEM_ARB_RR_EN
    logic              r_rr_last;
`endif

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic          w_sel1;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [DW-1:0] w_wdata;
    logic          w_own_req;
    logic          w_own_lock;
    logic          w_regrant;

    assign w_req = {req1, req0};

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .i_rr_last (r_rr_last),
`endif
        .i_req     (w_req),
        .o_gnt     (w_pick)
    );

    // In IDLE the new winner's inputs are loaded; in DONE the current owner's (burst re-grant).
    assign w_sel1     = (r_state == IDLE) ? w_pick[P1] : gnt[P1];
    assign w_addr     = w_sel1 ? addr1  : addr0;
    assign w_we       = w_sel1 ? we1    : we0;
    assign w_wdata    = w_sel1 ? wdata1 : wdata0;
    assign w_own_req  = gnt[P1] ? req1  : req0;
    assign w_own_lock = gnt[P1] ? lock1 : lock0;
    assign w_regrant  = w_own_req && w_own_lock && (r_hold_cnt < HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
`ifdef MEM_ARB_RR_EN
            r_rr_last  <= 1'b1;
`endif
            rdy0       <= 1'b0;
            rdy1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            gnt        <= 2'b00;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            rdy0 <= 1'b0;
            rdy1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        mem_addr  <= w_addr;
                        mem_we    <= w_we;
                        mem_wdata <= w_wdata;
                        gnt       <= w_pick;
`ifdef MEM_ARB_RR_EN
                        r_rr_last <= w_pick[P1];
`endif
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (gnt[P1]) begin
                        rdy1 <= 1'b1;
                        if (!mem_we) rdata1 <= mem_rdata;
                    end else begin
                        rdy0 <= 1'b1;
                        if (!mem_we) rdata0 <= mem_rdata;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    if (w_regrant) begin
                        mem_addr  <= w_addr;
                        mem_we    <= w_we;
                        mem_wdata <= w_wdata;
                        if (r_hold_cnt != HOLD_SAT) r_hold_cnt <= r_hold_cnt + 1'b1;
                        r_state   <= ACCESS;
                    end else begin
                        gnt        <= 2'b00;
                        r_hold_cnt <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
